axi_ddr_slave_model: RTL

- AXI4 full slave (responder) backed by on-chip RAM; 64-bit data, INCR bursts up to 256 beats.
- Stands in for the PS DDR port on the acquisition path, so the ADC burst writer/reader masters can run in PL-only simulation and bring-up.
- Write and read channels are independent. The block is also usable as a small PL scratch buffer.

---
 rtl/axi_ddr_pkg.sv | 26 ++
 rtl/axi_ddr_slave_model_ram.sv | 27 ++
 rtl/axi_ddr_slave_model.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/axi_ddr_pkg.sv
// rtl/axi_ddr_pkg.sv - shared constants and window check for the AXI DDR stand-in slave
package axi_ddr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Last byte is computed at 33 bits so a burst running past 4 GiB cannot wrap back into the window.
  function automatic logic burst_bad(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst,
                                     input logic [31:0] base, input logic [32:0] span);
    logic [32:0] last;
    last = {1'b0, addr} + ({25'd0, len} + 33'd1) * 33'd8 - 33'd1;
    return (burst != BURST_INCR) || (size != SIZE_8B) ||
           ({1'b0, addr} < {1'b0, base}) || (last >= ({1'b0, base} + span));
  endfunction

endpackage

// File: rtl/axi_ddr_slave_model_ram.sv
// rtl/axi_ddr_slave_model_ram.sv - simple dual-port RAM, byte-enable write, read-first sync read
module sdp_ram_be #(
  parameter int DW = 64,
  parameter int AW = 12
) (
  input  logic            ACLK,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW/8-1:0] wbe,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge ACLK) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_ddr_slave_model.sv
// rtl/axi_ddr_slave_model.sv - AXI4 INCR slave backed by on-chip RAM, independent write and read FSMs
module axi_ddr_slave_model
  import axi_ddr_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_AW     = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic                    S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic                    S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic                    S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam logic [32:0] SPAN = 33'd8 << MEM_AW;

  // Keeps the address READYs low while ARESETN is asserted even though both FSMs sit in IDLE.
  logic live;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) live <= 1'b0;
    else          live <= 1'b1;
  end

  logic [1:0]            w_state;
  logic [MEM_AW-1:0]     w_addr;
  logic [7:0]            w_cnt;
  logic                  w_err;
  logic                  aw_hs, w_hs, beat_bad, ram_we;

  assign S_AXI_AWREADY = live && (w_state == W_IDLE);
  assign S_AXI_WREADY  = (w_state == W_DATA);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = (S_AXI_BVALID && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign beat_bad = S_AXI_WLAST != (w_cnt == 8'd0);
  assign ram_we   = w_hs && !w_err && !beat_bad;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      S_AXI_BID <= 1'b0;
      w_addr    <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          S_AXI_BID <= S_AXI_AWID;
          w_addr    <= S_AXI_AWADDR[MEM_AW+2:3];
          w_cnt     <= S_AXI_AWLEN;
          w_err     <= burst_bad(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                                 BASE_ADDR, SPAN);
          w_state   <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_addr <= w_addr + MEM_AW'(1);
          w_cnt  <= w_cnt - 8'd1;
          if (beat_bad) w_err <= 1'b1;
          if (w_cnt == 8'd0) w_state <= W_RESP;
        end
        W_RESP: if (S_AXI_BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  logic [0:0]            r_state;
  logic                  r_err, q_valid, q_last;
  logic [MEM_AW-1:0]     f_addr;
  logic [7:0]            f_cnt;
  logic                  ar_hs, r_adv, ram_re;
  logic [MEM_AW-1:0]     ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;

  assign S_AXI_ARREADY = live && (r_state == R_IDLE);
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_adv     = !S_AXI_RVALID || S_AXI_RREADY;
  assign ram_re    = ar_hs || ((r_state == R_DATA) && r_adv && (f_cnt != 8'd0));
  assign ram_raddr = (r_state == R_IDLE) ? S_AXI_ARADDR[MEM_AW+2:3] : f_addr;

  // Two-stage pipe: RAM output (q_*) feeds the R output register; both move only when the R slot frees.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= R_IDLE;
      S_AXI_RID    <= 1'b0;
      r_err        <= 1'b0;
      f_addr       <= '0;
      f_cnt        <= '0;
      q_valid      <= 1'b0;
      q_last       <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RLAST  <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      if (r_adv) begin
        S_AXI_RVALID <= q_valid;
        S_AXI_RLAST  <= q_valid && q_last;
        S_AXI_RDATA  <= (q_valid && !r_err) ? ram_q : '0;
        S_AXI_RRESP  <= (q_valid && r_err) ? RESP_SLVERR : RESP_OKAY;
      end
      case (r_state)
        R_IDLE: if (ar_hs) begin
          S_AXI_RID <= S_AXI_ARID;
          r_err     <= burst_bad(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
                                 BASE_ADDR, SPAN);
          f_addr    <= S_AXI_ARADDR[MEM_AW+2:3] + MEM_AW'(1);
          f_cnt     <= S_AXI_ARLEN;
          q_valid   <= 1'b1;
          q_last    <= (S_AXI_ARLEN == 8'd0);
          r_state   <= R_DATA;
        end
        R_DATA: begin
          if (r_adv) begin
            if (f_cnt != 8'd0) begin
              f_addr  <= f_addr + MEM_AW'(1);
              f_cnt   <= f_cnt - 8'd1;
              q_valid <= 1'b1;
              q_last  <= (f_cnt == 8'd1);
            end else begin
              q_valid <= 1'b0;
            end
          end
          if (S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  sdp_ram_be #(.DW(DATA_WIDTH), .AW(MEM_AW)) u_ram (
    .ACLK  (ACLK),
    .we    (ram_we),
    .waddr (w_addr),
    .wbe   (S_AXI_WSTRB),
    .wdata (S_AXI_WDATA),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

endmodule
